// File: rtl/e_muldiv.sv
// rtl/e_muldiv.sv - E-stage multiply/divide unit owning the HI/LO registers
//
// Executes mult/multu/div/divu as a fixed-latency multi-cycle operation and
// serves mthi/mtlo/mfhi/mflo against the architectural HI/LO registers.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   Instr_E  in   instruction in E (opcode 0, funct decoded)
//   RD1_E    in   rs value: multiplicand / dividend / mthi-mtlo source
//   RD2_E    in   rt value: multiplier / divisor
//   Start    out  mult/div accepted this cycle (combinational)
//   Busy     out  operation in progress (registered)
//   HI, LO   out  architectural HI/LO
//   MD_out   out  HI for mfhi, LO for mflo, otherwise 0 (combinational)
module e_muldiv #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_E,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MD_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nxt;

   // ---------------- decode ----------------
   logic [5:0] funct;
   logic       is_special, is_md, is_div, is_mthi, is_mtlo, is_mfhi, is_mflo;
   logic       unused_bits;

   assign funct       = Instr_E[5:0];
   assign is_special  = (Instr_E[31:26] == 6'd0);
   // mult/multu/div/divu occupy funct 0x18..0x1B; bit 1 separates div from mult
   assign is_md       = is_special && (funct[5:2] == 4'b0110);
   assign is_div      = funct[1];
   assign is_mthi     = is_special && (funct == 6'h11);
   assign is_mtlo     = is_special && (funct == 6'h13);
   assign is_mfhi     = is_special && (funct == 6'h10);
   assign is_mflo     = is_special && (funct == 6'h12);
   assign unused_bits = ^Instr_E[25:6];

   // ---------------- latched operation ----------------
   logic [31:0]   a_q, b_q;
   logic [1:0]    op_q;        // funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu
   logic [CW-1:0] cnt;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (is_md) state_nxt = BUSY;
         BUSY: if (cnt == CW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   logic finish, wr_hi, wr_lo;

   always_comb begin
      Start  = 1'b0;
      Busy   = 1'b0;
      finish = 1'b0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      case (state)
         IDLE: begin
            Start = is_md;
            wr_hi = is_mthi;
            wr_lo = is_mtlo;
         end
         BUSY: begin
            Busy   = 1'b1;
            finish = (cnt == CW'(1));
         end
         default: ;
      endcase
      MD_out = is_mfhi ? HI : (is_mflo ? LO : 32'd0);
   end

   // ---------------- result datapath ----------------
   logic [63:0] mul_s, mul_u, res;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, safe_b, q_mag, r_mag, quo, rem;

   assign mul_u = {32'd0, a_q} * {32'd0, b_q};
   assign mul_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

   // Signed divide on magnitudes: quotient sign is the XOR of operand signs,
   // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
   assign neg_a  = (op_q == 2'b10) && a_q[31];
   assign neg_b  = (op_q == 2'b10) && b_q[31];
   assign mag_a  = neg_a ? -a_q : a_q;
   assign mag_b  = neg_b ? -b_q : b_q;
   assign safe_b = (b_q == 32'd0) ? 32'd1 : mag_b;
   assign q_mag  = mag_a / safe_b;
   assign r_mag  = mag_a % safe_b;
   assign quo    = (neg_a ^ neg_b) ? -q_mag : q_mag;
   assign rem    = neg_a ? -r_mag : r_mag;

   always_comb begin
      case (op_q)
         2'b00:   res = mul_s;
         2'b01:   res = mul_u;
         default: res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quo};
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         op_q <= 2'b00;
         cnt  <= '0;
         HI   <= 32'd0;
         LO   <= 32'd0;
      end else begin
         if (Start) begin
            a_q  <= RD1_E;
            b_q  <= RD2_E;
            op_q <= funct[1:0];
            cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
         end
         if (finish) begin
            HI <= res[63:32];
            LO <= res[31:0];
         end else begin
            if (wr_hi) HI <= RD1_E;
            if (wr_lo) LO <= RD1_E;
         end
      end
   end

endmodule

// File: tb/tb_e_muldiv.sv
// tb/tb_e_muldiv.sv - self-checking bench for e_muldiv
module tb_e_muldiv;

   localparam int NM = 5;
   localparam int ND = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr_E, RD1_E, RD2_E;
   logic        Start, Busy;
   logic [31:0] HI, LO, MD_out;

   int passed = 0;
   int total  = 0;

   e_muldiv #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk(clk), .reset(reset), .Instr_E(Instr_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
      .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MD_out(MD_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ins(input logic [5:0] f);
      logic [19:0] mid;
      mid = 20'($urandom);
      return {6'd0, mid, f};
   endfunction

   // Reference: {HI, LO} from plain arithmetic
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0] qq, rr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         6'h18: return 64'(sa * sb);
         6'h19: return 64'(ua * ub);
         6'h1A: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb; r = sa % sb;
            qq = q; rr = r;
            return {rr[31:0], qq[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub; ur = ua % ub;
            qq = uq; rr = ur;
            return {rr[31:0], qq[31:0]};
         end
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one mult/div from idle; returns what was observed. Ends in cycle N+1.
   task automatic issue_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic st, output int nbusy,
                           output logic [31:0] hi_o, output logic [31:0] lo_o);
      Instr_E = ins(f); RD1_E = a; RD2_E = b;
      #1;
      st = Start;
      step();
      Instr_E = 32'd0; RD1_E = $urandom; RD2_E = $urandom;
      nbusy = 0;
      while (Busy && nbusy < 200) begin
         nbusy++;
         step();
      end
      hi_o = HI; lo_o = LO;
   endtask

   task automatic test_reset();
      Instr_E = 32'd0; RD1_E = 32'd0; RD2_E = 32'd0;
      reset = 1'b1;
      repeat (2) step();
      total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", Busy); else passed++;
      total++; if (HI !== 32'd0) $display("FAIL reset_hi got %h want 0", HI); else passed++;
      total++; if (LO !== 32'd0) $display("FAIL reset_lo got %h want 0", LO); else passed++;
      total++; if (Start !== 1'b0) $display("FAIL reset_start got %0b want 0", Start); else passed++;
      total++; if (MD_out !== 32'd0) $display("FAIL reset_md_out got %h want 0", MD_out); else passed++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_mult();
      logic st; int n; logic [31:0] h, l;
      issue_op(6'h18, 32'hFFFF_FFFF, 32'd2, st, n, h, l);
      total++; if (st !== 1'b1) $display("FAIL mult_start got %0b want 1", st); else passed++;
      total++; if (n != NM) $display("FAIL mult_busy_cycles got %0d want %0d", n, NM); else passed++;
      total++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFE)
         $display("FAIL mult_result got %h_%h want ffffffff_fffffffe", h, l); else passed++;
      issue_op(6'h19, 32'hFFFF_FFFF, 32'd2, st, n, h, l);
      total++; if (h !== 32'h1 || l !== 32'hFFFF_FFFE)
         $display("FAIL multu_result got %h_%h want 00000001_fffffffe", h, l); else passed++;
   endtask

   task automatic test_div();
      logic st; int n; logic [31:0] h, l;
      issue_op(6'h1A, 32'hFFFF_FFF9, 32'd2, st, n, h, l);
      total++; if (n != ND) $display("FAIL div_busy_cycles got %0d want %0d", n, ND); else passed++;
      total++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD)
         $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", h, l); else passed++;
      issue_op(6'h1B, 32'd7, 32'd0, st, n, h, l);
      total++; if (h !== 32'd7 || l !== 32'hFFFF_FFFF)
         $display("FAIL divu_by_zero got %h_%h want 00000007_ffffffff", h, l); else passed++;
      issue_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, st, n, h, l);
      total++; if (h !== 32'd0 || l !== 32'h8000_0000)
         $display("FAIL div_overflow got %h_%h want 00000000_80000000", h, l); else passed++;
      issue_op(6'h1A, 32'hFFFF_FFF9, 32'd0, st, n, h, l);
      total++; if (h !== 32'hFFFF_FFF9 || l !== 32'hFFFF_FFFF)
         $display("FAIL div_by_zero got %h_%h want fffffff9_ffffffff", h, l); else passed++;
   endtask

   task automatic test_isolation();
      int bad_start = 0;
      int k;
      Instr_E = ins(6'h18); RD1_E = 32'd3; RD2_E = 32'd4;
      step();
      for (int i = 0; i < NM; i++) begin
         Instr_E = (i % 2 == 0) ? ins(6'h18) : 32'($urandom);
         RD1_E = $urandom; RD2_E = $urandom;
         #1;
         if (Start !== 1'b0) bad_start++;
         step();
      end
      Instr_E = 32'd0;
      total++; if (bad_start != 0) $display("FAIL iso_start_while_busy got %0d starts want 0", bad_start); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL iso_busy_end got %0b want 0", Busy); else passed++;
      total++; if (HI !== 32'd0 || LO !== 32'd12)
         $display("FAIL iso_result got %h_%h want 00000000_0000000c", HI, LO); else passed++;
      k = 0;
      repeat (3) begin step(); if (Busy) k++; end
      total++; if (k != 0) $display("FAIL iso_no_second_start got %0d busy cycles want 0", k); else passed++;
   endtask

   task automatic test_mthi_mtlo();
      int k;
      Instr_E = ins(6'h13); RD1_E = 32'hCAFE_F00D; step();
      Instr_E = ins(6'h11); RD1_E = 32'h1234_5678; step();
      Instr_E = ins(6'h10); RD1_E = $urandom; #1;
      total++; if (HI !== 32'h1234_5678) $display("FAIL mthi_hi got %h want 12345678", HI); else passed++;
      total++; if (MD_out !== 32'h1234_5678) $display("FAIL mfhi_md_out got %h want 12345678", MD_out); else passed++;
      Instr_E = ins(6'h12); #1;
      total++; if (MD_out !== 32'hCAFE_F00D) $display("FAIL mflo_md_out got %h want cafef00d", MD_out); else passed++;
      Instr_E = 32'd0; #1;
      total++; if (MD_out !== 32'd0) $display("FAIL nop_md_out got %h want 0", MD_out); else passed++;
      step();
      // multu 0x10000 * 0x10000 with mtlo and mfhi arriving while busy
      Instr_E = ins(6'h19); RD1_E = 32'h1_0000; RD2_E = 32'h1_0000; step();
      Instr_E = ins(6'h13); RD1_E = 32'h0000_DEAD; step();
      Instr_E = ins(6'h10); #1;
      total++; if (LO !== 32'hCAFE_F00D) $display("FAIL mtlo_busy_lo got %h want cafef00d", LO); else passed++;
      total++; if (MD_out !== 32'h1234_5678) $display("FAIL mfhi_busy_md_out got %h want 12345678", MD_out); else passed++;
      Instr_E = 32'd0;
      k = 0;
      while (Busy && k < 50) begin k++; step(); end
      total++; if (HI !== 32'd1 || LO !== 32'd0)
         $display("FAIL mtlo_busy_final got %h_%h want 00000001_00000000", HI, LO); else passed++;
   endtask

   task automatic test_back_to_back();
      int n;
      Instr_E = ins(6'h1B); RD1_E = 32'd100; RD2_E = 32'd7; step();
      Instr_E = 32'd0;
      n = 1;
      while (Busy && n < 100) begin n++; step(); end
      n--;
      total++; if (n != ND) $display("FAIL b2b_div_cycles got %0d want %0d", n, ND); else passed++;
      total++; if (HI !== 32'd2 || LO !== 32'd14)
         $display("FAIL b2b_div_result got %h_%h want 00000002_0000000e", HI, LO); else passed++;
      Instr_E = ins(6'h19); RD1_E = 32'd5; RD2_E = 32'd5; #1;
      total++; if (Start !== 1'b1) $display("FAIL b2b_start got %0b want 1", Start); else passed++;
      step();
      Instr_E = 32'd0;
      total++; if (Busy !== 1'b1) $display("FAIL b2b_busy_gap got %0b want 1", Busy); else passed++;
      n = 0;
      while (Busy && n < 100) begin n++; step(); end
      total++; if (n != NM) $display("FAIL b2b_mul_cycles got %0d want %0d", n, NM); else passed++;
      total++; if (HI !== 32'd0 || LO !== 32'd25)
         $display("FAIL b2b_mul_result got %h_%h want 00000000_00000019", HI, LO); else passed++;
   endtask

   task automatic test_random();
      logic [5:0] fs [6];
      logic [5:0] f; logic [31:0] a, b, h, l; logic st; int n;
      logic [63:0] e;
      logic [31:0] exp_hi, exp_lo;
      fs[0] = 6'h18; fs[1] = 6'h19; fs[2] = 6'h1A; fs[3] = 6'h1B; fs[4] = 6'h11; fs[5] = 6'h13;
      exp_hi = HI; exp_lo = LO;   // carried over from the previous directed test
      total++; if (exp_hi !== 32'd0 || exp_lo !== 32'd25)
         $display("FAIL rand_seed_state got %h_%h want 00000000_00000019", exp_hi, exp_lo); else passed++;
      for (int i = 0; i < 30; i++) begin
         f = fs[$urandom_range(0, 5)];
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         if (f == 6'h11 || f == 6'h13) begin
            Instr_E = ins(f); RD1_E = a; step();
            Instr_E = 32'd0;
            if (f == 6'h11) exp_hi = a; else exp_lo = a;
         end else begin
            issue_op(f, a, b, st, n, h, l);
            e = model(f, a, b);
            exp_hi = e[63:32]; exp_lo = e[31:0];
            total++; if (n != ((f[1]) ? ND : NM))
               $display("FAIL rand_cycles[%0d] f=%h got %0d", i, f, n); else passed++;
         end
         Instr_E = ins(6'h10); #1;
         total++; if (MD_out !== exp_hi)
            $display("FAIL rand_hi[%0d] f=%h a=%h b=%h got %h want %h", i, f, a, b, MD_out, exp_hi); else passed++;
         Instr_E = ins(6'h12); #1;
         total++; if (MD_out !== exp_lo)
            $display("FAIL rand_lo[%0d] f=%h a=%h b=%h got %h want %h", i, f, a, b, MD_out, exp_lo); else passed++;
         Instr_E = 32'd0;
         step();
      end
   endtask

   task automatic test_async_reset();
      logic st; int n, k; logic [31:0] h, l;
      Instr_E = ins(6'h11); RD1_E = 32'h5555_AAAA; step();
      Instr_E = ins(6'h13); RD1_E = 32'h1357_9BDF; step();
      Instr_E = ins(6'h1A); RD1_E = 32'd1000; RD2_E = 32'd3; step();
      Instr_E = 32'd0;
      repeat (3) step();          // now in busy cycle 4
      #2 reset = 1'b1;
      #1;
      total++; if (Busy !== 1'b0) $display("FAIL areset_busy got %0b want 0", Busy); else passed++;
      total++; if (HI !== 32'd0 || LO !== 32'd0)
         $display("FAIL areset_hilo got %h_%h want 0_0", HI, LO); else passed++;
      #2 reset = 1'b0;
      k = 0;
      repeat (ND + 3) begin step(); if (Busy || HI != 0 || LO != 0) k++; end
      total++; if (k != 0) $display("FAIL areset_no_write got %0d bad cycles want 0", k); else passed++;
      issue_op(6'h18, 32'hFFFF_FFFD, 32'd7, st, n, h, l);
      total++; if (st !== 1'b1 || n != NM || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB)
         $display("FAIL areset_restart got st=%0b n=%0d %h_%h want 1 5 ffffffff_ffffffeb", st, n, h, l);
      else passed++;
   endtask

   initial begin
      reset = 1'b1;
      Instr_E = 32'd0; RD1_E = 32'd0; RD2_E = 32'd0;
      test_reset();
      test_mult();
      test_div();
      test_isolation();
      test_mthi_mtlo();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
